// File: rtl/ya_fifo_pkg.sv
// Shared constants for the FIFO-to-stream bridge.
//   DEF_WORD_SIZE : default data width of the FIFO / stream words
//   DEF_PKT_LEN   : default number of beats per stream packet
//   beat_cnt_w()  : width of a counter spanning 0..pkt_len-1 (never below 1)
package ya_fifo_pkg;

    localparam int DEF_WORD_SIZE = 8;
    localparam int DEF_PKT_LEN   = 16;

    function automatic int beat_cnt_w(input int pkt_len);
        int w;
        w = $clog2(pkt_len);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ya_stream_skid_buf.sv
// Two-entry in-order word buffer sitting between the FIFO read port and the
// stream output. slot0 always holds the oldest word.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset, clears occupancy and data
//   clear      : synchronous discard of all buffered words (data kept)
//   push       : capture push_data this cycle
//   push_data  : word to capture
//   pop        : oldest word consumed this cycle
//   head       : oldest buffered word
//   occupancy  : number of buffered words, 0..2
module ya_stream_skid_buf
    import ya_fifo_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 push,
    input  logic [WORD_SIZE-1:0] push_data,
    input  logic                 pop,
    output logic [WORD_SIZE-1:0] head,
    output logic [1:0]           occupancy
);

    logic [WORD_SIZE-1:0] slot0;
    logic [WORD_SIZE-1:0] slot1;
    logic [1:0]           occ;

    // The read-issue logic upstream guarantees push never arrives with two
    // words already held, and pop is only raised while occupancy is nonzero.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ   <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (clear) begin
            occ <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) slot0 <= push_data;
                    else             slot1 <= push_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    occ   <= occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind whatever
                    // remains after the pop.
                    if (occ == 2'd2) begin
                        slot0 <= slot1;
                        slot1 <= push_data;
                    end else begin
                        slot0 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head      = slot0;
    assign occupancy = occ;

endmodule

// File: rtl/ya_fifo_to_stream.sv
// Bridge from a standard-mode (registered read data, FWFT=0) FIFO to a
// valid/ready stream with packet framing every PKT_LEN beats.
//   i_clk            : clock, rising edge
//   i_reset          : synchronous active-high reset, highest priority
//   i_flush          : discard buffered / in-flight words and packet position
//   o_fifo_re        : FIFO read request
//   i_fifo_not_empty : FIFO non-empty flag
//   i_fifo_data      : FIFO read data, valid the cycle after a read
//   o_tvalid         : stream word valid
//   i_tready         : stream sink ready
//   o_tdata          : stream word
//   o_tlast          : final beat of each packet
module ya_fifo_to_stream
    import ya_fifo_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int PKT_LEN   = DEF_PKT_LEN
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_flush,
    output logic                 o_fifo_re,
    input  logic                 i_fifo_not_empty,
    input  logic [WORD_SIZE-1:0] i_fifo_data,
    output logic                 o_tvalid,
    input  logic                 i_tready,
    output logic [WORD_SIZE-1:0] o_tdata,
    output logic                 o_tlast
);

    localparam int                BEAT_W    = beat_cnt_w(PKT_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

    logic              inflight;
    logic [BEAT_W-1:0] beat;
    logic [1:0]        occ;
    logic [WORD_SIZE-1:0] head;
    logic              pop;
    logic              push;
    logic              issue;
    logic [2:0]        load;

    assign pop = o_tvalid & i_tready;

    // Words committed to the buffer once this cycle settles: held words plus
    // the one returning from the FIFO, minus the one leaving. A new read is
    // only safe if at most one slot is spoken for, so the buffer never
    // overflows yet a steady one-in/one-out flow keeps reading every cycle.
    assign load = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    assign o_fifo_re = i_fifo_not_empty & ~i_flush & ~i_reset & (load <= 3'd1);
    assign issue     = o_fifo_re & i_fifo_not_empty;

    // A word arriving in the flush cycle belongs to the discarded stream.
    assign push = inflight & ~i_flush;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            beat <= '0;
        end else if (pop) begin
            if (beat == LAST_BEAT) beat <= '0;
            else                   beat <= beat + BEAT_W'(1);
        end
    end

    ya_stream_skid_buf #(
        .WORD_SIZE (WORD_SIZE)
    ) u_buf (
        .clk       (i_clk),
        .rst       (i_reset),
        .clear     (i_flush),
        .push      (push),
        .push_data (i_fifo_data),
        .pop       (pop),
        .head      (head),
        .occupancy (occ)
    );

    assign o_tvalid = (occ != 2'd0);
    assign o_tdata  = head;
    assign o_tlast  = o_tvalid & (beat == LAST_BEAT);

endmodule

// File: tb/tb_ya_fifo_to_stream.sv
module tb_ya_fifo_to_stream;

    localparam int PKT_A = 16;
    localparam int PKT_B = 1;

    typedef struct {
        logic [7:0] d;
        int         cyc;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       flush;
    logic       tready;
    logic       flush_b;
    logic       tready_b;

    logic       re_a, ne_a, tv_a, tl_a;
    logic [7:0] fd_a, td_a;
    logic       re_b, ne_b, tv_b, tl_b;
    logic [7:0] fd_b, td_b;

    // Standard-mode FIFO models: read data appears the cycle after a read.
    logic [7:0] mem_a [0:1023];
    logic [7:0] mem_b [0:63];
    int wp_a = 0;
    int rp_a = 0;
    int wp_b = 0;
    int rp_b = 0;

    assign ne_a = (wp_a != rp_a);
    assign ne_b = (wp_b != rp_b);

    always @(posedge clk) begin
        if (re_a && ne_a) begin
            fd_a <= mem_a[rp_a];
            rp_a <= rp_a + 1;
        end
    end

    always @(posedge clk) begin
        if (re_b && ne_b) begin
            fd_b <= mem_b[rp_b];
            rp_b <= rp_b + 1;
        end
    end

    ya_fifo_to_stream #(.WORD_SIZE(8), .PKT_LEN(PKT_A)) dut_a (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_flush          (flush),
        .o_fifo_re        (re_a),
        .i_fifo_not_empty (ne_a),
        .i_fifo_data      (fd_a),
        .o_tvalid         (tv_a),
        .i_tready         (tready),
        .o_tdata          (td_a),
        .o_tlast          (tl_a)
    );

    ya_fifo_to_stream #(.WORD_SIZE(8), .PKT_LEN(PKT_B)) dut_b (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_flush          (flush_b),
        .o_fifo_re        (re_b),
        .i_fifo_not_empty (ne_b),
        .i_fifo_data      (fd_b),
        .o_tvalid         (tv_b),
        .i_tready         (tready_b),
        .o_tdata          (td_b),
        .o_tlast          (tl_b)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: words read from the FIFO, in order, with the cycle of
    // their read; a word is visible on the stream two cycles after its read.
    ent_t pq[$];
    int   beat  = 0;
    int   now   = 0;
    logic stall = 1'b0;

    logic [7:0] exp_b   = 8'h01;
    int         beats_b = 0;

    logic       s_tv, s_pop, s_tl;
    logic [7:0] s_td;

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic [7:0] v);
        mem_a[wp_a] = v;
        wp_a++;
    endtask

    task automatic push_b(input logic [7:0] v);
        mem_b[wp_b] = v;
        wp_b++;
    endtask

    task automatic step();
        int   vis;
        logic exp_v;
        logic pop;
        @(negedge clk);
        vis = 0;
        foreach (pq[i]) if (pq[i].cyc <= now - 2) vis++;
        exp_v = (vis != 0);
        pop   = tv_a && tready;
        check(32'(vis <= 2), 1, "buf_occ_le2");
        check(tv_a, exp_v, "tvalid");
        if (exp_v) begin
            check(td_a, pq[0].d, "tdata");
            check(tl_a, (beat == PKT_A - 1), "tlast");
        end else begin
            check(tl_a, 0, "tlast_idle");
        end
        check(re_a && !ne_a, 0, "re_while_empty");
        if (rst || flush) check(re_a, 0, "re_in_clear");
        if (stall) check(tv_a, 1, "stall_hold");
        check(tl_b, tv_b, "b_tlast");
        if (tv_b) begin
            check(td_b, exp_b, "b_tdata");
            exp_b++;
            beats_b++;
        end
        s_tv  = tv_a;
        s_pop = pop;
        s_td  = td_a;
        s_tl  = tl_a;
        if (pop && exp_v) begin
            void'(pq.pop_front());
            beat = (beat + 1) % PKT_A;
        end
        if (re_a && ne_a) pq.push_back('{d: mem_a[rp_a], cyc: now});
        stall = tv_a && !tready && !rst && !flush;
        if (rst || flush) begin
            pq.delete();
            beat  = 0;
            stall = 1'b0;
        end
        now++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, first, last, nlast, start, lastpos;
        logic [7:0] exp_next;

        rst      = 1'b1;
        flush    = 1'b0;
        tready   = 1'b0;
        flush_b  = 1'b0;
        tready_b = 1'b1;
        @(posedge clk);
        #1;
        step();
        step();
        check(tv_a, 0, "rst_tvalid");
        check(tl_a, 0, "rst_tlast");
        check(td_a, 0, "rst_tdata");
        check(re_a, 0, "rst_re");
        check(td_b, 0, "rst_b_tdata");

        // Continuous stream of 32 words, sink always ready
        rst    = 1'b0;
        tready = 1'b1;
        for (int i = 0; i < 32; i++) push_a(8'(i));
        start = now; first = -1; last = -1; n = 0; nlast = 0;
        for (int c = 0; c < 50; c++) begin
            step();
            if (s_pop) begin
                if (first < 0) first = now - 1;
                last = now - 1;
                n++;
                if (s_tl) nlast++;
            end
        end
        check(n, 32, "stream_beats");
        check(first - start, 2, "stream_first_latency");
        check(last - first, 31, "stream_consecutive");
        check(nlast, 2, "stream_tlast_count");

        // Backpressure: ready toggles every cycle
        for (int i = 0; i < 8; i++) push_a(8'(8'h40 + i));
        n = 0;
        for (int c = 0; c < 40; c++) begin
            tready = c[0];
            step();
            if (s_pop) n++;
        end
        check(n, 8, "bp_beats");

        // Single word into an empty FIFO
        tready = 1'b1;
        step();
        push_a(8'hA5);
        start = now; first = -1; n = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (s_tv) begin
                if (first < 0) first = now - 1;
                n++;
            end
        end
        check(first - start, 2, "underflow_latency");
        check(n, 1, "underflow_valid_cycles");

        // Flush after five beats of a packet
        for (int i = 0; i < 32; i++) push_a(8'(8'h10 + i));
        n = 0;
        for (int c = 0; c < 30 && n < 5; c++) begin
            step();
            if (s_pop) n++;
        end
        check(n, 5, "flush_pre_beats");
        flush = 1'b1;
        step();
        flush = 1'b0;
        exp_next = mem_a[rp_a];
        n = 0; lastpos = 0;
        for (int c = 0; c < 60 && n < 16; c++) begin
            step();
            if (s_pop) begin
                n++;
                if (n == 1) check(s_td, exp_next, "flush_next_word");
                if (s_tl && lastpos == 0) lastpos = n;
            end
        end
        check(lastpos, 16, "flush_tlast_pos");
        repeat (20) step();
        check(tv_a, 0, "flush_drained");

        // Reset while two words sit in the buffer
        tready = 1'b0;
        for (int i = 0; i < 4; i++) push_a(8'(8'h60 + i));
        repeat (6) step();
        check(s_tv, 1, "prerst_valid");
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check(s_tv, 0, "rst_mid_tvalid");
        for (int i = 0; i < 14; i++) push_a(8'(8'h64 + i));
        tready = 1'b1;
        n = 0; lastpos = 0;
        for (int c = 0; c < 40 && n < 16; c++) begin
            step();
            if (s_pop) begin
                n++;
                if (s_tl && lastpos == 0) lastpos = n;
            end
        end
        check(n, 16, "rst_mid_beats");
        check(lastpos, 16, "rst_mid_tlast_pos");

        // Randomized traffic with occasional flushes
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) push_a(8'($urandom_range(0, 255)));
            tready = 1'($urandom_range(0, 1));
            flush  = ($urandom_range(0, 39) == 0);
            step();
        end
        flush  = 1'b0;
        tready = 1'b1;
        repeat (30) step();
        check(tv_a, 0, "random_drained");
        check(32'(pq.size()), 0, "random_model_empty");

        // Single-beat packets
        for (int i = 1; i <= 4; i++) push_b(8'(i));
        repeat (12) step();
        check(beats_b, 4, "b_beats");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
